// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control unit. It sequences each instruction through one shared
// ALU and one memory port, and drives the mux selects and write strobes of the datapath. A
// wait-counter watchdog bounds every memory access. Illegal opcodes and watchdog expiry park the
// FSM in a terminal trap state.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   opcode, funct3, funct7_5       instruction fields taken from the instruction register
//   alu_zero                       ALU result is zero (used for branch resolution)
//   mem_ready                      memory completes the current request
//   mem_req, mem_we, adr_sel       memory request, write strobe, address select (0=PC, 1=ALUOUT)
//   ir_write, pc_write, pc_src     IR load, PC load, PC source (0=ALU result, 1=ALUOUT)
//   src_a_sel, src_b_sel           ALU operand selects
//   alu_func, shamt_sel, shift_op  ALU operation, shift-amount source, shift flavour
//   dest_sel, reg_write            regfile write-data select and write enable
//   instr_done                     one-cycle retire pulse
//   trap, mem_err                  sticky trap flag, and whether the trap came from a timeout
module mc_controller #(
  parameter int         MEM_WAIT_MAX = 15,
  parameter int         CNT_W        = 4,
  parameter logic [2:0] ALU_ADD      = 3'b000,
  parameter logic [2:0] ALU_SUB      = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] src_a_sel,
  output logic [1:0] src_b_sel,
  output logic [2:0] alu_func,
  output logic       shamt_sel,
  output logic [1:0] shift_op,
  output logic [1:0] dest_sel,
  output logic       reg_write,
  output logic       instr_done,
  output logic       trap,
  output logic       mem_err
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  // Remaining ALU codes; the three shifts share one code and are told apart by shift_op.
  localparam logic [2:0] AluShift = 3'b010;
  localparam logic [2:0] AluSlt   = 3'b011;
  localparam logic [2:0] AluSltu  = 3'b100;
  localparam logic [2:0] AluXor   = 3'b101;
  localparam logic [2:0] AluOr    = 3'b110;
  localparam logic [2:0] AluAnd   = 3'b111;

  // The trap fires in the stalled cycle that would bring the count up to MEM_WAIT_MAX.
  localparam int              LimM1   = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam logic [CNT_W-1:0] WaitLim = CNT_W'(LimM1);

  typedef enum logic [3:0] {
    StBoot, StFetch, StDecode, StExec, StAluWb, StMemAddr,
    StMemRd, StMemWb, StMemWr, StBranch, StJal, StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, mem_err_q;
  logic             wait_hit;
  logic             is_op;

  assign mem_req  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign wait_hit = (MEM_WAIT_MAX > 0) && mem_req && !mem_ready && (cnt_q == WaitLim);
  // Counting only while stalled and zeroing otherwise also clears it on entry to any access.
  assign cnt_d    = (mem_req && !mem_ready) ? cnt_q + 1'b1 : '0;
  assign is_op    = (opcode == OpcOp);
  assign shift_op = {funct7_5, funct3[2]};
  assign trap     = trap_q;
  assign mem_err  = mem_err_q;

  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    adr_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    src_a_sel  = 2'b00;
    src_b_sel  = 2'b00;
    alu_func   = '0;
    shamt_sel  = 1'b0;
    dest_sel   = 2'b00;
    reg_write  = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        src_b_sel = 2'b10;
        alu_func  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_hit) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        src_a_sel = 2'b01;
        src_b_sel = 2'b01;
        alu_func  = ALU_ADD;
        case (opcode)
          OpcOp, OpcOpImm, OpcLui: state_d = StExec;
          OpcLoad, OpcStore:       state_d = StMemAddr;
          OpcBranch: state_d = (funct3[2:1] == 2'b00) ? StBranch : StTrap;
          OpcJal:                  state_d = StJal;
          default:                 state_d = StTrap;
        endcase
      end
      StExec: begin
        state_d = StAluWb;
        if (opcode == OpcLui) begin
          src_a_sel = 2'b11;
          src_b_sel = 2'b01;
          alu_func  = ALU_ADD;
        end else begin
          src_a_sel = 2'b10;
          src_b_sel = is_op ? 2'b00 : 2'b01;
          shamt_sel = !is_op;
          case (funct3)
            3'b000:         alu_func = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001, 3'b101: alu_func = AluShift;
            3'b010:         alu_func = AluSlt;
            3'b011:         alu_func = AluSltu;
            3'b100:         alu_func = AluXor;
            3'b110:         alu_func = AluOr;
            default:        alu_func = AluAnd;
          endcase
        end
      end
      StAluWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemAddr: begin
        src_a_sel = 2'b10;
        src_b_sel = 2'b01;
        alu_func  = ALU_ADD;
        state_d   = (opcode == OpcStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        adr_sel = 1'b1;
        if (mem_ready)     state_d = StMemWb;
        else if (wait_hit) state_d = StTrap;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        dest_sel   = 2'b01;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        adr_sel = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (wait_hit) begin
          state_d = StTrap;
        end
      end
      StBranch: begin
        src_a_sel  = 2'b10;
        alu_func   = ALU_SUB;
        pc_src     = 1'b1;
        // funct3[0] inverts the sense: BEQ takes on zero, BNE on non-zero.
        pc_write   = alu_zero ^ funct3[0];
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        reg_write  = 1'b1;
        dest_sel   = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_q | (state_d == StTrap);
      mem_err_q <= mem_err_q | wait_hit;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle expected output vectors are queued with their stimulus
// and compared as the DUT steps through each instruction.
module tb_mc_controller;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // Bit positions of the mux fields inside the observed vector.
  localparam int FAdr = 17, FPcSrc = 14, FDest = 11, FA = 6, FB = 4, FAlu = 1, FSh = 0;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_sel, ir_write, pc_write, pc_src, shamt_sel;
  logic       reg_write, instr_done, trap, mem_err;
  logic [1:0] src_a_sel, src_b_sel, shift_op, dest_sel;
  logic [2:0] alu_func;

  always #5 clk = ~clk;

  mc_controller #(
    .MEM_WAIT_MAX(15), .CNT_W(4), .ALU_ADD(3'b000), .ALU_SUB(3'b001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_sel(adr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .alu_func(alu_func), .shamt_sel(shamt_sel),
    .shift_op(shift_op), .dest_sel(dest_sel), .reg_write(reg_write), .instr_done(instr_done),
    .trap(trap), .mem_err(mem_err)
  );

  typedef struct { logic [19:0] val; logic [19:0] care; } exp_t;
  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f75;
    logic       ready;
    logic       zero;
    exp_t       e;
  } item_t;

  item_t      sbq[$];
  item_t      it;
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic       cur_f75;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [19:0] obs();
    return {mem_req, mem_we, adr_sel, ir_write, pc_write, pc_src, reg_write, dest_sel,
            instr_done, trap, mem_err, src_a_sel, src_b_sel, alu_func, shamt_sel};
  endfunction

  // Strobes are always cared about; mux fields only where fld() adds them.
  function automatic exp_t st(int req, int we, int irw, int pcw, int regw, int done, int trp,
                              int err);
    exp_t e;
    e.val = '0;
    e.val[19] = req[0]; e.val[18] = we[0]; e.val[16] = irw[0]; e.val[15] = pcw[0];
    e.val[13] = regw[0]; e.val[10] = done[0]; e.val[9] = trp[0]; e.val[8] = err[0];
    e.care = 20'hDA700;
    return e;
  endfunction

  function automatic exp_t fld(exp_t e, int lo, int w, int v);
    for (int i = 0; i < w; i++) begin
      e.val[lo+i]  = v[i];
      e.care[lo+i] = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t e_boot();
    return st(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_fetch(int r);
    exp_t e = fld(st(1, 0, r, r, 0, 0, 0, 0), FAdr, 1, 0);
    if (r != 0) e = fld(fld(fld(fld(e, FA, 2, 0), FB, 2, 2), FAlu, 3, 0), FPcSrc, 1, 0);
    return e;
  endfunction
  function automatic exp_t e_decode();
    return fld(fld(fld(st(0, 0, 0, 0, 0, 0, 0, 0), FA, 2, 1), FB, 2, 1), FAlu, 3, 0);
  endfunction
  function automatic exp_t e_exec(int a, int b, int alu, int sh);
    exp_t e = fld(fld(fld(st(0, 0, 0, 0, 0, 0, 0, 0), FA, 2, a), FB, 2, b), FAlu, 3, alu);
    if (sh >= 0) e = fld(e, FSh, 1, sh);
    return e;
  endfunction
  function automatic exp_t e_aluwb();
    return fld(st(0, 0, 0, 0, 1, 1, 0, 0), FDest, 2, 0);
  endfunction
  function automatic exp_t e_memaddr();
    return fld(fld(fld(st(0, 0, 0, 0, 0, 0, 0, 0), FA, 2, 2), FB, 2, 1), FAlu, 3, 0);
  endfunction
  function automatic exp_t e_memrd();
    return fld(st(1, 0, 0, 0, 0, 0, 0, 0), FAdr, 1, 1);
  endfunction
  function automatic exp_t e_memwb();
    return fld(st(0, 0, 0, 0, 1, 1, 0, 0), FDest, 2, 1);
  endfunction
  function automatic exp_t e_memwr(int r);
    return fld(st(1, 1, 0, 0, 0, r, 0, 0), FAdr, 1, 1);
  endfunction
  function automatic exp_t e_branch(int pcw);
    exp_t e = fld(fld(st(0, 0, 0, pcw, 0, 1, 0, 0), FA, 2, 2), FB, 2, 0);
    return fld(fld(e, FAlu, 3, 1), FPcSrc, 1, 1);
  endfunction
  function automatic exp_t e_jal();
    return fld(fld(st(0, 0, 0, 1, 1, 1, 0, 0), FDest, 2, 2), FPcSrc, 1, 1);
  endfunction
  function automatic exp_t e_trap(int err);
    return st(0, 0, 0, 0, 0, 0, 1, err);
  endfunction

  function automatic void set_ir(logic [6:0] o, logic [2:0] f, logic b);
    cur_opc = o; cur_f3 = f; cur_f75 = b;
  endfunction

  function automatic void push(string name, int r, int z, exp_t e);
    item_t i;
    i.name = name; i.opc = cur_opc; i.f3 = cur_f3; i.f75 = cur_f75;
    i.ready = r[0]; i.zero = z[0]; i.e = e;
    sbq.push_back(i);
  endfunction

  task automatic test_reset();
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (obs() !== 20'h0 || shift_op !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %05h want 00000", obs());
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    set_ir(OpcOp, 3'b000, 1'b0);
    push("add.boot", 1, 0, e_boot());
    push("add.fetch", 1, 0, e_fetch(1));
    push("add.decode", 1, 0, e_decode());
    push("add.exec", 1, 0, e_exec(2, 0, 0, 0));
    push("add.alu_wb", 1, 0, e_aluwb());
    rst_n = 1'b1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_variants();
    set_ir(OpcOp, 3'b000, 1'b1);
    push("sub.fetch", 1, 0, e_fetch(1)); push("sub.decode", 1, 0, e_decode());
    push("sub.exec", 1, 0, e_exec(2, 0, 1, 0)); push("sub.alu_wb", 1, 0, e_aluwb());
    set_ir(OpcOpImm, 3'b000, 1'b1);
    push("addi_b30.fetch", 1, 0, e_fetch(1)); push("addi_b30.decode", 1, 0, e_decode());
    push("addi_b30.exec", 1, 0, e_exec(2, 1, 0, 1)); push("addi_b30.alu_wb", 1, 0, e_aluwb());
    set_ir(OpcOp, 3'b111, 1'b0);
    push("and.fetch", 1, 0, e_fetch(1)); push("and.decode", 1, 0, e_decode());
    push("and.exec", 1, 0, e_exec(2, 0, 7, 0)); push("and.alu_wb", 1, 0, e_aluwb());
    set_ir(OpcLui, 3'b011, 1'b1);
    push("lui.fetch", 1, 0, e_fetch(1)); push("lui.decode", 1, 0, e_decode());
    push("lui.exec", 1, 0, e_exec(3, 1, 0, -1)); push("lui.alu_wb", 1, 0, e_aluwb());
    set_ir(OpcOpImm, 3'b101, 1'b1);
    push("srai.fetch", 1, 0, e_fetch(1)); push("srai.decode", 1, 0, e_decode());
    push("srai.exec", 1, 0, e_exec(2, 1, 2, 1)); push("srai.alu_wb", 1, 0, e_aluwb());
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (shift_op !== 2'b11) begin
      n_bad++;
      $display("FAIL srai.shift_op: got %b want 11", shift_op);
    end
  endtask

  task automatic test_load_stall();
    set_ir(OpcLoad, 3'b010, 1'b0);
    push("lw.fetch", 1, 0, e_fetch(1)); push("lw.decode", 1, 0, e_decode());
    push("lw.mem_addr", 1, 0, e_memaddr());
    for (int i = 0; i < 3; i++) push("lw.mem_rd_stall", 0, 0, e_memrd());
    push("lw.mem_rd_ready", 1, 0, e_memrd());
    push("lw.mem_wb", 1, 0, e_memwb());
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_jal();
    set_ir(OpcStore, 3'b010, 1'b0);
    push("sw.fetch", 1, 0, e_fetch(1)); push("sw.decode", 1, 0, e_decode());
    push("sw.mem_addr", 1, 0, e_memaddr());
    push("sw.mem_wr_stall", 0, 0, e_memwr(0)); push("sw.mem_wr_ready", 1, 0, e_memwr(1));
    set_ir(OpcJal, 3'b000, 1'b0);
    push("jal.fetch", 1, 0, e_fetch(1)); push("jal.decode", 1, 0, e_decode());
    push("jal.jal", 1, 0, e_jal());
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    set_ir(OpcBranch, 3'b001, 1'b0);
    push("bne_nz.fetch", 1, 0, e_fetch(1)); push("bne_nz.decode", 1, 0, e_decode());
    push("bne_nz.branch", 1, 0, e_branch(1));
    set_ir(OpcBranch, 3'b000, 1'b0);
    push("beq_nz.fetch", 1, 0, e_fetch(1)); push("beq_nz.decode", 1, 0, e_decode());
    push("beq_nz.branch", 1, 0, e_branch(0));
    push("beq_z.fetch", 1, 1, e_fetch(1)); push("beq_z.decode", 1, 1, e_decode());
    push("beq_z.branch", 1, 1, e_branch(1));
    set_ir(OpcBranch, 3'b001, 1'b0);
    push("bne_z.fetch", 1, 1, e_fetch(1)); push("bne_z.decode", 1, 1, e_decode());
    push("bne_z.branch", 1, 1, e_branch(0));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  // Ready arrives in the 15th stalled-or-ready FETCH cycle: must complete, not trap.
  task automatic test_wait_limit();
    set_ir(OpcOp, 3'b100, 1'b0);
    for (int i = 0; i < 14; i++) push("limit.fetch_stall", 0, 0, e_fetch(0));
    push("limit.fetch_ready", 1, 0, e_fetch(1));
    push("limit.decode", 1, 0, e_decode());
    push("limit.exec", 1, 0, e_exec(2, 0, 5, 0));
    push("limit.alu_wb", 1, 0, e_aluwb());
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    set_ir(OpcOp, 3'b000, 1'b0);
    for (int i = 0; i < 15; i++) push("timeout.fetch_stall", 0, 0, e_fetch(0));
    for (int i = 0; i < 3; i++) push("timeout.trap", 1, 0, e_trap(1));
    set_ir(OpcOp, 3'b000, 1'b0);
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    set_ir(OpcSystem, 3'b000, 1'b0);
    push("illegal.boot", 1, 0, e_boot()); push("illegal.fetch", 1, 0, e_fetch(1));
    push("illegal.decode", 1, 0, e_decode());
    push("illegal.trap", 1, 0, e_trap(0)); push("illegal.trap_hold", 1, 0, e_trap(0));
    rst_n = 1'b1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    set_ir(OpcBranch, 3'b100, 1'b0);
    push("blt.boot", 1, 0, e_boot()); push("blt.fetch", 1, 0, e_fetch(1));
    push("blt.decode", 1, 0, e_decode()); push("blt.trap", 1, 0, e_trap(0));
    rst_n = 1'b1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    set_ir(OpcStore, 3'b010, 1'b0);
    push("rstmid.boot", 1, 0, e_boot()); push("rstmid.fetch", 1, 0, e_fetch(1));
    push("rstmid.decode", 1, 0, e_decode()); push("rstmid.mem_addr", 1, 0, e_memaddr());
    push("rstmid.mem_wr_stall", 0, 0, e_memwr(0));
    rst_n = 1'b1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
    #2;
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid.before_reset: mem_req got %b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_we, adr_sel} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid.async_drop: {req,we,adr} got %b want 000", {mem_req, mem_we, adr_sel});
    end
    @(negedge clk);
    push("rstmid.reboot", 1, 0, e_boot()); push("rstmid.refetch", 1, 0, e_fetch(1));
    push("rstmid.redecode", 1, 0, e_decode()); push("rstmid.remem_addr", 1, 0, e_memaddr());
    push("rstmid.mem_wr_ready", 1, 0, e_memwr(1));
    rst_n = 1'b1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      opcode = it.opc; funct3 = it.f3; funct7_5 = it.f75; mem_ready = it.ready; alu_zero = it.zero;
      #1;
      n_vec++;
      if ((obs() & it.e.care) !== (it.e.val & it.e.care)) begin
        n_bad++;
        $display("FAIL %s: got %05h want %05h (care %05h)", it.name, obs() & it.e.care,
                 it.e.val, it.e.care);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_variants();
    test_load_stall();
    test_store_jal();
    test_branch();
    test_wait_limit();
    test_timeout();
    test_illegal();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
